io_bus_arbiter: RTL and testbench

- Shares one memory-mapped IO peripheral bus between several core memory-access stages.
- Each core presents io read/write requests: 16-bit offset zero-extended to a 32-bit address.
- Arbiter grants round-robin, drives the bus with wait-state support (bus_ready) and a timeout, then returns an ack, read data and an error flag to the granted core.
- Sits between the per-core IO ports and the shared peripheral fabric.

---
 rtl/io_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_arbiter
//  Description : Round-robin arbiter sharing one memory-mapped IO peripheral
//                bus between several core memory-access stages. Supports
//                peripheral wait states (bus_ready) with a bounded timeout and
//                returns ack / read data / error to the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQUESTERS-1:0]    req_read_en,
    input  logic [NUM_REQUESTERS-1:0]    req_write_en,
    input  logic [32*NUM_REQUESTERS-1:0] req_address,
    input  logic [32*NUM_REQUESTERS-1:0] req_write_data,
    output logic [NUM_REQUESTERS-1:0]    req_ack,
    output logic [NUM_REQUESTERS-1:0]    req_error,
    output logic [31:0]                  req_read_data,
    output logic                         bus_read_en,
    output logic                         bus_write_en,
    output logic [31:0]                  bus_address,
    output logic [31:0]                  bus_write_data,
    input  logic                         bus_ready,
    input  logic [31:0]                  bus_read_data
);

    // Index width for requester numbers; one extra bit is used for the
    // modular add so that wrap-around can be handled with a single subtract.
    localparam int                c_IDX_W   = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam logic [c_IDX_W:0]  c_NUM     = (c_IDX_W+1)'(NUM_REQUESTERS);
    localparam logic [7:0]        c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [NUM_REQUESTERS-1:0] w_pending;
    logic [NUM_REQUESTERS-1:0] w_rotated;
    logic [2*NUM_REQUESTERS-1:0] w_doubled;
    logic                      w_any_pending;
    logic [c_IDX_W:0]          w_offset;
    logic [c_IDX_W:0]          w_grant_sum;
    logic [c_IDX_W-1:0]        w_grant_idx;
    logic [c_IDX_W:0]          w_ptr_sum;
    logic [c_IDX_W-1:0]        w_ptr_next;
    logic                      w_grant_is_write;
    logic                      w_timeout_hit;

    logic [c_IDX_W-1:0]        r_rr_ptr;
    logic [c_IDX_W-1:0]        r_grant;
    logic                      r_is_write;
    logic [7:0]                r_timeout_cnt;
    logic [NUM_REQUESTERS-1:0] r_req_ack;
    logic [NUM_REQUESTERS-1:0] r_req_error;
    logic [31:0]               r_req_read_data;
    logic                      r_bus_read_en;
    logic                      r_bus_write_en;
    logic [31:0]               r_bus_address;
    logic [31:0]               r_bus_write_data;

    assign w_pending = req_read_en | req_write_en;

    // Rotate the pending vector so that bit 0 corresponds to rr_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_doubled = {w_pending, w_pending} >> r_rr_ptr;
    assign w_rotated = w_doubled[NUM_REQUESTERS-1:0];

    // Priority search for the first pending requester at or after rr_ptr.
    always_comb begin
        w_any_pending = 1'b0;
        w_offset      = '0;
        for (int off = 0; off < NUM_REQUESTERS; off++) begin
            if (!w_any_pending && w_rotated[off]) begin
                w_any_pending = 1'b1;
                w_offset      = (c_IDX_W+1)'(off);
            end
        end
    end

    // Convert the rotated offset back into an absolute index, modulo N.
    assign w_grant_sum = {1'b0, r_rr_ptr} + w_offset;
    assign w_grant_idx = (w_grant_sum >= c_NUM) ? c_IDX_W'(w_grant_sum - c_NUM)
                                                : c_IDX_W'(w_grant_sum);

    // The pointer moves to the requester just after the one being granted.
    assign w_ptr_sum  = {1'b0, w_grant_idx} + (c_IDX_W+1)'(1);
    assign w_ptr_next = (w_ptr_sum >= c_NUM) ? c_IDX_W'(w_ptr_sum - c_NUM)
                                             : c_IDX_W'(w_ptr_sum);

    // A request with both enables set is serviced as a write.
    assign w_grant_is_write = req_write_en[w_grant_idx];

    // The current cycle is the TIMEOUT_CYCLES-th consecutive not-ready cycle.
    assign w_timeout_hit = !bus_ready && ((r_timeout_cnt + 8'd1) == c_TIMEOUT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> BUS on grant, BUS -> RESP on ready/timeout,
    // RESP always returns to IDLE so the acked request is never re-sampled.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_pending) begin
                    w_state_next = S_BUS;
                end
            end
            S_BUS: begin
                if (bus_ready || w_timeout_hit) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Registered datapath: grant latching, bus strobes, timeout count and
    // the response returned to the granted requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr         <= '0;
            r_grant          <= '0;
            r_is_write       <= 1'b0;
            r_timeout_cnt    <= 8'd0;
            r_req_ack        <= '0;
            r_req_error      <= '0;
            r_req_read_data  <= 32'd0;
            r_bus_read_en    <= 1'b0;
            r_bus_write_en   <= 1'b0;
            r_bus_address    <= 32'd0;
            r_bus_write_data <= 32'd0;
        end else begin
            r_req_ack   <= '0;
            r_req_error <= '0;
            case (r_state)
                S_IDLE: begin
                    r_timeout_cnt <= 8'd0;
                    if (w_any_pending) begin
                        r_grant          <= w_grant_idx;
                        r_rr_ptr         <= w_ptr_next;
                        r_is_write       <= w_grant_is_write;
                        r_bus_address    <= req_address[{w_grant_idx, 5'b00000} +: 32];
                        r_bus_write_data <= req_write_data[{w_grant_idx, 5'b00000} +: 32];
                        r_bus_write_en   <= w_grant_is_write;
                        r_bus_read_en    <= !w_grant_is_write;
                    end
                end
                S_BUS: begin
                    if (bus_ready) begin
                        r_bus_read_en   <= 1'b0;
                        r_bus_write_en  <= 1'b0;
                        r_req_read_data <= r_is_write ? 32'd0 : bus_read_data;
                        r_req_ack       <= NUM_REQUESTERS'(1) << r_grant;
                    end else if (w_timeout_hit) begin
                        r_bus_read_en   <= 1'b0;
                        r_bus_write_en  <= 1'b0;
                        r_req_read_data <= 32'hFFFF_FFFF;
                        r_req_ack       <= NUM_REQUESTERS'(1) << r_grant;
                        r_req_error     <= NUM_REQUESTERS'(1) << r_grant;
                        r_timeout_cnt   <= r_timeout_cnt + 8'd1;
                    end else begin
                        r_timeout_cnt   <= r_timeout_cnt + 8'd1;
                    end
                end
                default: begin
                    // RESP: ack pulse is already on the outputs; nothing to do.
                end
            endcase
        end
    end

    assign req_ack        = r_req_ack;
    assign req_error      = r_req_error;
    assign req_read_data  = r_req_read_data;
    assign bus_read_en    = r_bus_read_en;
    assign bus_write_en   = r_bus_write_en;
    assign bus_address    = r_bus_address;
    assign bus_write_data = r_bus_write_data;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bus_arbiter
//  Description : Directed self-checking bench for io_bus_arbiter. A second
//                instance with TIMEOUT_CYCLES=4 shares the stimulus and is
//                used for the timeout scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

    localparam int c_N = 4;

    logic            clk;
    logic            reset;
    logic [c_N-1:0]  req_read_en;
    logic [c_N-1:0]  req_write_en;
    logic [32*c_N-1:0] req_address;
    logic [32*c_N-1:0] req_write_data;
    logic            bus_ready;
    logic [31:0]     bus_read_data;

    logic [c_N-1:0]  req_ack,   t_req_ack;
    logic [c_N-1:0]  req_error, t_req_error;
    logic [31:0]     req_read_data, t_req_read_data;
    logic            bus_read_en,  t_bus_read_en;
    logic            bus_write_en, t_bus_write_en;
    logic [31:0]     bus_address,  t_bus_address;
    logic [31:0]     bus_write_data, t_bus_write_data;

    int n_checks;
    int n_fail;

    io_bus_arbiter #(.NUM_REQUESTERS(c_N), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .req_read_en(req_read_en), .req_write_en(req_write_en),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_ack(req_ack), .req_error(req_error), .req_read_data(req_read_data),
        .bus_read_en(bus_read_en), .bus_write_en(bus_write_en),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_ready(bus_ready), .bus_read_data(bus_read_data)
    );

    io_bus_arbiter #(.NUM_REQUESTERS(c_N), .TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .reset(reset),
        .req_read_en(req_read_en), .req_write_en(req_write_en),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_ack(t_req_ack), .req_error(t_req_error), .req_read_data(t_req_read_data),
        .bus_read_en(t_bus_read_en), .bus_write_en(t_bus_write_en),
        .bus_address(t_bus_address), .bus_write_data(t_bus_write_data),
        .bus_ready(bus_ready), .bus_read_data(bus_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_read_en = '0; req_write_en = '0;
        req_address = '0; req_write_data = '0;
        bus_ready = 1'b0; bus_read_data = 32'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ack !== 4'b0 || req_error !== 4'b0) begin
            n_fail++; $display("FAIL reset_ack_err: ack=%b err=%b expected 0000/0000", req_ack, req_error);
        end
        n_checks++;
        if (bus_read_en !== 1'b0 || bus_write_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: rd=%b wr=%b expected 0/0", bus_read_en, bus_write_en);
        end
        n_checks++;
        if (bus_address !== 32'd0 || bus_write_data !== 32'd0 || req_read_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected 0", bus_address, bus_write_data, req_read_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        req_address[32*1 +: 32] = 32'h0000_0040;
        req_read_en = 4'b0010;
        bus_ready = 1'b1;
        bus_read_data = 32'hCAFE_0001;
        @(negedge clk);
        n_checks++;
        if (bus_read_en !== 1'b1 || bus_write_en !== 1'b0 || bus_address !== 32'h40 || req_ack !== 4'b0) begin
            n_fail++; $display("FAIL read_strobe: rd=%b wr=%b addr=%h ack=%b expected 1/0/00000040/0000",
                               bus_read_en, bus_write_en, bus_address, req_ack);
        end
        @(negedge clk);
        n_checks++;
        if (req_ack !== 4'b0010 || req_error !== 4'b0 || bus_read_en !== 1'b0) begin
            n_fail++; $display("FAIL read_ack: ack=%b err=%b rd=%b expected 0010/0000/0", req_ack, req_error, bus_read_en);
        end
        n_checks++;
        if (req_read_data !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL read_data: got %h expected cafe0001", req_read_data);
        end
        req_read_en = '0;
        @(negedge clk);
        n_checks++;
        if (req_ack !== 4'b0) begin
            n_fail++; $display("FAIL read_ack_width: ack=%b expected 0000", req_ack);
        end
    endtask

    task automatic test_round_robin();
        int order[5];
        int n_acks;
        int last_cyc;
        order = '{0, 1, 2, 3, 0};
        n_acks = 0;
        last_cyc = 0;
        pulse_reset();
        for (int i = 0; i < c_N; i++) begin
            req_address[32*i +: 32]    = 32'h0000_0100 + 32'(i * 16);
            req_write_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
        end
        req_write_en = 4'b1111;
        bus_ready = 1'b1;
        bus_read_data = 32'h5555_AAAA;
        for (int cyc = 1; cyc <= 40 && n_acks < 5; cyc++) begin
            @(negedge clk);
            if (req_ack !== 4'b0) begin
                n_checks++;
                if (req_ack !== (4'b1 << order[n_acks])) begin
                    n_fail++; $display("FAIL rr_order[%0d]: ack=%b expected requester %0d", n_acks, req_ack, order[n_acks]);
                end
                n_checks++;
                if (cyc !== 2 + 3 * n_acks) begin
                    n_fail++; $display("FAIL rr_spacing[%0d]: ack at cycle %0d expected %0d", n_acks, cyc, 2 + 3 * n_acks);
                end
                n_checks++;
                if (bus_address !== 32'h0000_0100 + 32'(order[n_acks] * 16) || req_read_data !== 32'd0) begin
                    n_fail++; $display("FAIL rr_addr[%0d]: addr=%h rdata=%h expected %h/00000000", n_acks,
                                       bus_address, req_read_data, 32'h0000_0100 + 32'(order[n_acks] * 16));
                end
                req_write_en = req_write_en & ~req_ack;
                if (n_acks == 3) req_write_en[0] = 1'b1;
                n_acks++;
                last_cyc = cyc;
            end
        end
        n_checks++;
        if (n_acks !== 5) begin
            n_fail++; $display("FAIL rr_count: saw %0d acks expected 5 (last at cycle %0d)", n_acks, last_cyc);
        end
        req_write_en = '0;
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        req_address[32*2 +: 32]    = 32'h0000_0008;
        req_write_data[32*2 +: 32] = 32'h0000_1234;
        bus_ready = 1'b0;
        bus_read_data = 32'hDEAD_BEEF;
        req_write_en = 4'b0100;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_write_en !== 1'b1 || bus_read_en !== 1'b0 || bus_address !== 32'h8 ||
                bus_write_data !== 32'h1234 || req_ack !== 4'b0) begin
                n_fail++; $display("FAIL wait_strobe[%0d]: wr=%b rd=%b addr=%h wdata=%h ack=%b expected 1/0/00000008/00001234/0000",
                                   i, bus_write_en, bus_read_en, bus_address, bus_write_data, req_ack);
            end
            if (i == 6) bus_ready = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (req_ack !== 4'b0100 || req_error !== 4'b0 || req_read_data !== 32'd0 || bus_write_en !== 1'b0) begin
            n_fail++; $display("FAIL wait_ack: ack=%b err=%b rdata=%h wr=%b expected 0100/0000/00000000/0",
                               req_ack, req_error, req_read_data, bus_write_en);
        end
        req_write_en = '0;
        @(negedge clk);
        n_checks++;
        if (req_ack !== 4'b0) begin
            n_fail++; $display("FAIL wait_single_ack: ack=%b expected 0000", req_ack);
        end
    endtask

    task automatic test_timeout();
        pulse_reset();
        req_address[32*3 +: 32] = 32'h0000_0030;
        bus_ready = 1'b0;
        req_read_en = 4'b1000;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (t_bus_read_en !== 1'b1 || t_req_ack !== 4'b0) begin
                n_fail++; $display("FAIL timeout_strobe[%0d]: rd=%b ack=%b expected 1/0000", i, t_bus_read_en, t_req_ack);
            end
        end
        @(negedge clk);
        n_checks++;
        if (t_bus_read_en !== 1'b0 || t_req_ack !== 4'b1000 || t_req_error !== 4'b1000) begin
            n_fail++; $display("FAIL timeout_ack: rd=%b ack=%b err=%b expected 0/1000/1000", t_bus_read_en, t_req_ack, t_req_error);
        end
        n_checks++;
        if (t_req_read_data !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL timeout_data: got %h expected ffffffff", t_req_read_data);
        end
        req_read_en = '0;
        @(negedge clk);
    endtask

    task automatic test_read_write_both();
        pulse_reset();
        req_address[32*0 +: 32]    = 32'h0000_0010;
        req_write_data[32*0 +: 32] = 32'h0BAD_F00D;
        bus_ready = 1'b1;
        bus_read_data = 32'h1111_2222;
        req_read_en  = 4'b0001;
        req_write_en = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (bus_write_en !== 1'b1 || bus_read_en !== 1'b0 || bus_write_data !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL rw_strobe: wr=%b rd=%b wdata=%h expected 1/0/0badf00d", bus_write_en, bus_read_en, bus_write_data);
        end
        @(negedge clk);
        n_checks++;
        if (req_ack !== 4'b0001 || req_error !== 4'b0 || req_read_data !== 32'd0) begin
            n_fail++; $display("FAIL rw_ack: ack=%b err=%b rdata=%h expected 0001/0000/00000000", req_ack, req_error, req_read_data);
        end
        req_read_en = '0;
        req_write_en = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus();
        // rr_ptr is 1 here; pending {0,2,3} grants 2 first.
        req_address[32*0 +: 32] = 32'h0000_0A00;
        req_address[32*2 +: 32] = 32'h0000_0A20;
        req_address[32*3 +: 32] = 32'h0000_0A30;
        bus_ready = 1'b0;
        req_write_en = 4'b1101;
        @(negedge clk);
        n_checks++;
        if (bus_write_en !== 1'b1 || bus_address !== 32'h0000_0A20) begin
            n_fail++; $display("FAIL midrst_grant: wr=%b addr=%h expected 1/00000a20", bus_write_en, bus_address);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_write_en !== 1'b0 || bus_read_en !== 1'b0 || req_ack !== 4'b0) begin
            n_fail++; $display("FAIL midrst_abort: wr=%b rd=%b ack=%b expected 0/0/0000", bus_write_en, bus_read_en, req_ack);
        end
        reset = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_write_en !== 1'b1 || bus_address !== 32'h0000_0A00 || req_ack !== 4'b0) begin
            n_fail++; $display("FAIL midrst_regrant: wr=%b addr=%h ack=%b expected 1/00000a00/0000", bus_write_en, bus_address, req_ack);
        end
        @(negedge clk);
        n_checks++;
        if (req_ack !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_ack: ack=%b expected 0001", req_ack);
        end
        req_write_en = '0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_wait_states();
        test_timeout();
        test_read_write_both();
        test_reset_mid_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
